// File: rtl/ap_ctrl_perf_monitor_if.sv
// Per-channel ap_ctrl handshake bundle observed by the performance monitor.
// The monitor only listens to start/done/continue and reports channel occupancy.
interface ap_ctrl_perf_monitor_if #(
    parameter int unsigned NUM_CH = 4
);
    logic [NUM_CH-1:0] ch_ap_start;
    logic [NUM_CH-1:0] ch_ap_done;
    logic [NUM_CH-1:0] ch_ap_continue;
    logic [NUM_CH-1:0] ch_busy;

    modport master (
        output ch_ap_start,
        output ch_ap_done,
        output ch_ap_continue,
        input  ch_busy
    );

    modport slave (
        input  ch_ap_start,
        input  ch_ap_done,
        input  ch_ap_continue,
        output ch_busy
    );
endinterface

// File: rtl/ap_ctrl_perf_monitor.sv
// Per-channel ap_ctrl transaction monitor: counts transactions, latency (last/min/max)
// and done-to-continue stall cycles, with freeze, clear and registered readback.
module ap_ctrl_perf_monitor #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 32,
    localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    ap_ctrl_perf_monitor_if.slave  ctrl,
    input  logic                   finish,
    input  logic                   clear,
    input  logic [SEL_W-1:0]       rd_sel,
    output logic [CNT_W-1:0]       rd_txn_cnt,
    output logic [CNT_W-1:0]       rd_last_lat,
    output logic [CNT_W-1:0]       rd_min_lat,
    output logic [CNT_W-1:0]       rd_max_lat,
    output logic [CNT_W-1:0]       rd_stall_cyc,
    output logic                   frozen
);
    typedef enum logic [1:0] {StIdle, StBusy, StDoneWait} state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e           state_q [NUM_CH];
    state_e           state_d [NUM_CH];
    logic [CNT_W-1:0] lat_q   [NUM_CH];
    logic [CNT_W-1:0] lat_d   [NUM_CH];
    logic [CNT_W-1:0] txn_q   [NUM_CH];
    logic [CNT_W-1:0] txn_d   [NUM_CH];
    logic [CNT_W-1:0] last_q  [NUM_CH];
    logic [CNT_W-1:0] last_d  [NUM_CH];
    logic [CNT_W-1:0] min_q   [NUM_CH];
    logic [CNT_W-1:0] min_d   [NUM_CH];
    logic [CNT_W-1:0] max_q   [NUM_CH];
    logic [CNT_W-1:0] max_d   [NUM_CH];
    logic [CNT_W-1:0] stall_q [NUM_CH];
    logic [CNT_W-1:0] stall_d [NUM_CH];
    logic             frozen_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CntMax) ? v : v + CntOne;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            logic             complete;
            logic [CNT_W-1:0] done_lat;
            complete   = 1'b0;
            done_lat   = '0;
            state_d[i] = state_q[i];
            lat_d[i]   = lat_q[i];
            txn_d[i]   = txn_q[i];
            last_d[i]  = last_q[i];
            min_d[i]   = min_q[i];
            max_d[i]   = max_q[i];
            stall_d[i] = stall_q[i];

            unique case (state_q[i])
                StIdle: begin
                    if (ctrl.ch_ap_start[i]) begin
                        if (ctrl.ch_ap_done[i]) begin
                            complete = 1'b1;
                            done_lat = CntOne;
                        end else begin
                            state_d[i] = StBusy;
                            lat_d[i]   = CntOne;
                        end
                    end
                end
                StBusy: begin
                    if (ctrl.ch_ap_done[i]) begin
                        complete = 1'b1;
                        done_lat = sat_inc(lat_q[i]);
                    end else begin
                        lat_d[i] = sat_inc(lat_q[i]);
                    end
                end
                StDoneWait: begin
                    // Late ap_done here is ignored; only continue releases the channel.
                    if (ctrl.ch_ap_continue[i]) begin
                        state_d[i] = StIdle;
                        lat_d[i]   = '0;
                        if (!frozen_q) txn_d[i] = sat_inc(txn_q[i]);
                    end else if (!frozen_q) begin
                        stall_d[i] = sat_inc(stall_q[i]);
                    end
                end
                default: state_d[i] = StIdle;
            endcase

            if (complete) begin
                if (!frozen_q) begin
                    last_d[i] = done_lat;
                    if (done_lat < min_q[i]) min_d[i] = done_lat;
                    if (done_lat > max_q[i]) max_d[i] = done_lat;
                end
                if (ctrl.ch_ap_continue[i]) begin
                    if (!frozen_q) txn_d[i] = sat_inc(txn_q[i]);
                    // The done cycle doubles as the accept cycle of a chained start.
                    state_d[i] = ctrl.ch_ap_start[i] ? StBusy : StIdle;
                    lat_d[i]   = ctrl.ch_ap_start[i] ? CntOne : '0;
                end else begin
                    state_d[i] = StDoneWait;
                    lat_d[i]   = done_lat;
                end
            end

            // Clear overrides any same-cycle statistic update; FSM and lat are untouched.
            if (clear && !frozen_q) begin
                txn_d[i]   = '0;
                last_d[i]  = '0;
                min_d[i]   = CntMax;
                max_d[i]   = '0;
                stall_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= StIdle;
                lat_q[i]   <= '0;
                txn_q[i]   <= '0;
                last_q[i]  <= '0;
                min_q[i]   <= CntMax;
                max_q[i]   <= '0;
                stall_q[i] <= '0;
            end
            frozen_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                lat_q[i]   <= lat_d[i];
                txn_q[i]   <= txn_d[i];
                last_q[i]  <= last_d[i];
                min_q[i]   <= min_d[i];
                max_q[i]   <= max_d[i];
                stall_q[i] <= stall_d[i];
            end
            if (finish) frozen_q <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_txn_cnt   <= '0;
            rd_last_lat  <= '0;
            rd_min_lat   <= CntMax;
            rd_max_lat   <= '0;
            rd_stall_cyc <= '0;
        end else if (32'(rd_sel) < NUM_CH) begin
            rd_txn_cnt   <= txn_q[rd_sel];
            rd_last_lat  <= last_q[rd_sel];
            rd_min_lat   <= min_q[rd_sel];
            rd_max_lat   <= max_q[rd_sel];
            rd_stall_cyc <= stall_q[rd_sel];
        end else begin
            rd_txn_cnt   <= '0;
            rd_last_lat  <= '0;
            rd_min_lat   <= '0;
            rd_max_lat   <= '0;
            rd_stall_cyc <= '0;
        end
    end

    always_comb begin
        ctrl.ch_busy = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ctrl.ch_busy[i] = (state_q[i] != StIdle);
        end
    end

    assign frozen = frozen_q;
endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// Directed bench for ap_ctrl_perf_monitor: a 4-channel 32-bit instance and a
// 3-channel 8-bit instance for saturation and out-of-range readback.
module tb_ap_ctrl_perf_monitor;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    // 4-channel, 32-bit instance
    ap_ctrl_perf_monitor_if #(.NUM_CH(4)) bus ();
    logic        finish = 1'b0;
    logic        clear  = 1'b0;
    logic [1:0]  rd_sel = '0;
    logic [31:0] rd_txn_cnt, rd_last_lat, rd_min_lat, rd_max_lat, rd_stall_cyc;
    logic        frozen;

    ap_ctrl_perf_monitor #(.NUM_CH(4), .CNT_W(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .ctrl         (bus),
        .finish       (finish),
        .clear        (clear),
        .rd_sel       (rd_sel),
        .rd_txn_cnt   (rd_txn_cnt),
        .rd_last_lat  (rd_last_lat),
        .rd_min_lat   (rd_min_lat),
        .rd_max_lat   (rd_max_lat),
        .rd_stall_cyc (rd_stall_cyc),
        .frozen       (frozen)
    );

    // 3-channel, 8-bit instance
    ap_ctrl_perf_monitor_if #(.NUM_CH(3)) bus8 ();
    logic       finish8 = 1'b0;
    logic       clear8  = 1'b0;
    logic [1:0] rd_sel8 = '0;
    logic [7:0] rd8_txn, rd8_last, rd8_min, rd8_max, rd8_stall;
    logic       frozen8;

    ap_ctrl_perf_monitor #(.NUM_CH(3), .CNT_W(8)) dut8 (
        .clock        (clock),
        .reset        (reset),
        .ctrl         (bus8),
        .finish       (finish8),
        .clear        (clear8),
        .rd_sel       (rd_sel8),
        .rd_txn_cnt   (rd8_txn),
        .rd_last_lat  (rd8_last),
        .rd_min_lat   (rd8_min),
        .rd_max_lat   (rd8_max),
        .rd_stall_cyc (rd8_stall),
        .frozen       (frozen8)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic read_ch(input logic [1:0] s);
        rd_sel = s;
        tick();
    endtask

    task automatic test_reset();
        bus.ch_ap_start = '0; bus.ch_ap_done = '0; bus.ch_ap_continue = '1;
        bus8.ch_ap_start = '0; bus8.ch_ap_done = '0; bus8.ch_ap_continue = '1;
        #2 reset = 1'b1;
        ticks(2);
        vectors++;
        if (rd_min_lat !== 32'hFFFF_FFFF) begin
            miscompares++; $display("FAIL reset_rd_min: got %0h want ffffffff", rd_min_lat);
        end
        vectors++;
        if ({rd_txn_cnt, rd_last_lat, rd_max_lat, rd_stall_cyc} !== 128'd0) begin
            miscompares++;
            $display("FAIL reset_rd_zero: got %0h %0h %0h %0h want 0", rd_txn_cnt, rd_last_lat,
                     rd_max_lat, rd_stall_cyc);
        end
        vectors++;
        if (bus.ch_busy !== 4'b0000 || frozen !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy_frozen: got %b %b want 0000 0", bus.ch_busy, frozen);
        end
        reset = 1'b0;
        ticks(2);
    endtask

    // ch0: accept at cycle A, done at A+9 -> latency 10
    task automatic test_basic_latency();
        bus.ch_ap_start[0] = 1'b1;
        tick();
        bus.ch_ap_start[0] = 1'b0;
        vectors++;
        if (bus.ch_busy[0] !== 1'b1) begin
            miscompares++; $display("FAIL basic_busy: got %b want 1", bus.ch_busy[0]);
        end
        ticks(8);
        bus.ch_ap_done[0] = 1'b1;
        tick();
        bus.ch_ap_done[0] = 1'b0;
        vectors++;
        if (bus.ch_busy[0] !== 1'b0) begin
            miscompares++; $display("FAIL basic_idle: got %b want 0", bus.ch_busy[0]);
        end
        read_ch(2'd0);
        vectors++;
        if (rd_txn_cnt !== 32'd1) begin
            miscompares++; $display("FAIL basic_txn: got %0d want 1", rd_txn_cnt);
        end
        vectors++;
        if (rd_last_lat !== 32'd10) begin
            miscompares++; $display("FAIL basic_last: got %0d want 10", rd_last_lat);
        end
        vectors++;
        if (rd_min_lat !== 32'd10 || rd_max_lat !== 32'd10) begin
            miscompares++;
            $display("FAIL basic_minmax: got %0d/%0d want 10/10", rd_min_lat, rd_max_lat);
        end
    endtask

    // ch1: latency 5, three DONE_WAIT cycles with continue low
    task automatic test_stall();
        bus.ch_ap_start[1] = 1'b1;
        tick();
        bus.ch_ap_start[1] = 1'b0;
        ticks(3);
        bus.ch_ap_done[1] = 1'b1;
        bus.ch_ap_continue[1] = 1'b0;
        tick();
        bus.ch_ap_done[1] = 1'b0;
        ticks(3);
        vectors++;
        if (bus.ch_busy[1] !== 1'b1) begin
            miscompares++; $display("FAIL stall_busy: got %b want 1", bus.ch_busy[1]);
        end
        bus.ch_ap_continue[1] = 1'b1;
        tick();
        read_ch(2'd1);
        vectors++;
        if (rd_stall_cyc !== 32'd3) begin
            miscompares++; $display("FAIL stall_cyc: got %0d want 3", rd_stall_cyc);
        end
        vectors++;
        if (rd_txn_cnt !== 32'd1 || rd_last_lat !== 32'd5) begin
            miscompares++;
            $display("FAIL stall_txn_last: got %0d/%0d want 1/5", rd_txn_cnt, rd_last_lat);
        end
    endtask

    // ch2: latency 4, chained start on the done cycle, then latency 6
    task automatic test_back_to_back();
        bus.ch_ap_start[2] = 1'b1;
        tick();
        bus.ch_ap_start[2] = 1'b0;
        ticks(2);
        bus.ch_ap_start[2] = 1'b1;
        bus.ch_ap_done[2] = 1'b1;
        tick();
        bus.ch_ap_start[2] = 1'b0;
        bus.ch_ap_done[2] = 1'b0;
        vectors++;
        if (bus.ch_busy[2] !== 1'b1) begin
            miscompares++; $display("FAIL b2b_busy: got %b want 1", bus.ch_busy[2]);
        end
        ticks(4);
        bus.ch_ap_done[2] = 1'b1;
        tick();
        bus.ch_ap_done[2] = 1'b0;
        read_ch(2'd2);
        vectors++;
        if (rd_txn_cnt !== 32'd2) begin
            miscompares++; $display("FAIL b2b_txn: got %0d want 2", rd_txn_cnt);
        end
        vectors++;
        if (rd_min_lat !== 32'd4 || rd_max_lat !== 32'd6 || rd_last_lat !== 32'd6) begin
            miscompares++;
            $display("FAIL b2b_lat: got min %0d max %0d last %0d want 4 6 6", rd_min_lat,
                     rd_max_lat, rd_last_lat);
        end
        read_ch(2'd3);
        vectors++;
        if (rd_min_lat !== 32'hFFFF_FFFF || rd_txn_cnt !== 32'd0) begin
            miscompares++;
            $display("FAIL unused_ch3: got min %0h txn %0d want ffffffff 0", rd_min_lat,
                     rd_txn_cnt);
        end
    endtask

    // 8-bit instance: latency 300 saturates at 255; rd_sel beyond NUM_CH reads 0
    task automatic test_saturation();
        bus8.ch_ap_start[0] = 1'b1;
        tick();
        bus8.ch_ap_start[0] = 1'b0;
        ticks(298);
        bus8.ch_ap_done[0] = 1'b1;
        tick();
        bus8.ch_ap_done[0] = 1'b0;
        rd_sel8 = 2'd0;
        tick();
        vectors++;
        if (rd8_last !== 8'd255 || rd8_max !== 8'd255) begin
            miscompares++;
            $display("FAIL sat_last_max: got %0d/%0d want 255/255", rd8_last, rd8_max);
        end
        vectors++;
        if (rd8_txn !== 8'd1) begin
            miscompares++; $display("FAIL sat_txn: got %0d want 1", rd8_txn);
        end
        rd_sel8 = 2'd3;
        tick();
        vectors++;
        if ({rd8_txn, rd8_last, rd8_min, rd8_max, rd8_stall} !== 40'd0) begin
            miscompares++;
            $display("FAIL sel_range: got min %0h txn %0d want 0 0", rd8_min, rd8_txn);
        end
    endtask

    // ch0: clear while busy, completion afterwards keeps the pre-clear cycles
    task automatic test_clear();
        bus.ch_ap_start[0] = 1'b1;
        tick();
        bus.ch_ap_start[0] = 1'b0;
        ticks(2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        read_ch(2'd1);
        vectors++;
        if (rd_txn_cnt !== 32'd0 || rd_min_lat !== 32'hFFFF_FFFF || rd_stall_cyc !== 32'd0) begin
            miscompares++;
            $display("FAIL clear_ch1: got txn %0d min %0h stall %0d want 0 ffffffff 0",
                     rd_txn_cnt, rd_min_lat, rd_stall_cyc);
        end
        tick();
        bus.ch_ap_done[0] = 1'b1;
        tick();
        bus.ch_ap_done[0] = 1'b0;
        read_ch(2'd0);
        vectors++;
        if (rd_txn_cnt !== 32'd1) begin
            miscompares++; $display("FAIL clear_txn: got %0d want 1", rd_txn_cnt);
        end
        vectors++;
        if (rd_last_lat !== 32'd7 || rd_min_lat !== 32'd7 || rd_max_lat !== 32'd7) begin
            miscompares++;
            $display("FAIL clear_lat: got last %0d min %0d max %0d want 7 7 7", rd_last_lat,
                     rd_min_lat, rd_max_lat);
        end
    endtask

    task automatic test_freeze();
        vectors++;
        if (frozen !== 1'b0) begin
            miscompares++; $display("FAIL prefreeze: got %b want 0", frozen);
        end
        finish = 1'b1;
        tick();
        finish = 1'b0;
        vectors++;
        if (frozen !== 1'b1) begin
            miscompares++; $display("FAIL frozen_set: got %b want 1", frozen);
        end
        bus.ch_ap_start[0] = 1'b1;
        tick();
        bus.ch_ap_start[0] = 1'b0;
        vectors++;
        if (bus.ch_busy[0] !== 1'b1) begin
            miscompares++; $display("FAIL frozen_fsm: got %b want 1", bus.ch_busy[0]);
        end
        tick();
        bus.ch_ap_done[0] = 1'b1;
        tick();
        bus.ch_ap_done[0] = 1'b0;
        read_ch(2'd0);
        vectors++;
        if (rd_txn_cnt !== 32'd1 || rd_last_lat !== 32'd7 || rd_min_lat !== 32'd7) begin
            miscompares++;
            $display("FAIL frozen_stats: got txn %0d last %0d min %0d want 1 7 7", rd_txn_cnt,
                     rd_last_lat, rd_min_lat);
        end
        vectors++;
        if (frozen !== 1'b1 || bus.ch_busy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL frozen_sticky: got %b busy %b want 1 0", frozen, bus.ch_busy[0]);
        end
    endtask

    task automatic test_reset_mid_txn();
        bus.ch_ap_start[3] = 1'b1;
        tick();
        bus.ch_ap_start[3] = 1'b0;
        tick();
        vectors++;
        if (bus.ch_busy[3] !== 1'b1) begin
            miscompares++; $display("FAIL mid_busy: got %b want 1", bus.ch_busy[3]);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (bus.ch_busy !== 4'b0000 || frozen !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_async: got busy %b frozen %b want 0000 0", bus.ch_busy,
                     frozen);
        end
        tick();
        reset = 1'b0;
        // done without start in IDLE is ignored
        bus.ch_ap_done[3] = 1'b1;
        tick();
        bus.ch_ap_done[3] = 1'b0;
        read_ch(2'd3);
        vectors++;
        if (rd_txn_cnt !== 32'd0 || rd_min_lat !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL mid_after: got txn %0d min %0h want 0 ffffffff", rd_txn_cnt,
                     rd_min_lat);
        end
        vectors++;
        if (bus.ch_busy[3] !== 1'b0) begin
            miscompares++; $display("FAIL idle_done_ignored: got %b want 0", bus.ch_busy[3]);
        end
    endtask

    initial begin
        test_reset();
        test_basic_latency();
        test_stall();
        test_back_to_back();
        test_saturation();
        test_clear();
        test_freeze();
        test_reset_mid_txn();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ap_ctrl_perf_monitor.md
AP_CTRL_PERF_MONITOR -- requirements
Module: ap_ctrl_perf_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of monitored ap_ctrl channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32, width of every statistic counter (8..64).
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port ch_ap_start  input  NUM_CH  per-channel ap_start.
REQ-006 SHALL have port ch_ap_done  input  NUM_CH  per-channel ap_done.
REQ-007 SHALL have port ch_ap_continue  input  NUM_CH  per-channel ap_continue; tie to 1 for non-chained modules.
REQ-008 SHALL have port finish  input  1  end of test; freezes all statistics.
REQ-009 SHALL have port clear  input  1  synchronous statistics clear.
REQ-010 SHALL have port rd_sel  input  max(1,$clog2(NUM_CH))  channel selected for readback.
REQ-011 SHALL have ports rd_txn_cnt, rd_last_lat, rd_min_lat, rd_max_lat, rd_stall_cyc  output  CNT_W each  statistics of the selected channel.
REQ-012 SHALL have port ch_busy  output  NUM_CH  1 while the channel FSM is not IDLE.
REQ-013 SHALL have port frozen  output  1  statistics frozen by finish.

Function
REQ-014 Each channel SHALL run an independent FSM with states IDLE, BUSY and DONE_WAIT, plus an in-flight latency counter lat.
REQ-015 IDLE, ap_start=1, ap_done=0: go to BUSY with lat=1.
REQ-016 BUSY, ap_done=0: lat increments by 1 and the FSM stays in BUSY.
REQ-017 BUSY, ap_done=1: last_lat is set to lat+1, and min_lat and max_lat are updated.
REQ-018 In the REQ-017 case with ap_continue=1: txn_cnt increments; go to BUSY with lat=1 if ap_start=1, else go to IDLE.
REQ-019 In the REQ-017 case with ap_continue=0: go to DONE_WAIT.
REQ-020 IDLE, ap_start=1, ap_done=1 in the same cycle: count as a latency-1 transaction and apply the REQ-018/REQ-019 rules.
REQ-021 DONE_WAIT: stall_cyc increments every cycle ap_continue=0; on ap_continue=1, txn_cnt increments and the FSM goes to IDLE.
REQ-022 ap_done in IDLE without ap_start, or in DONE_WAIT, SHALL be ignored.
REQ-023 Latency = cycles from the start-accept cycle to the done cycle, inclusive.
REQ-024 All counters and lat SHALL saturate at all-ones and never wrap.
REQ-025 min_lat SHALL hold all-ones until the first completed transaction.
REQ-026 finish=1 for one cycle SHALL set frozen=1 from the next cycle; frozen is sticky until reset.
REQ-027 While frozen=1, statistics SHALL not change; the FSMs and ch_busy keep running.
REQ-028 clear=1 SHALL zero txn_cnt, last_lat, max_lat and stall_cyc of all channels and set min_lat to all-ones next cycle.
REQ-029 clear SHALL not alter FSM state, lat or frozen.
REQ-030 clear and a completion in the same cycle: clear wins, so the completion is dropped.
REQ-031 Readback outputs SHALL be registered: values reflect rd_sel and the statistics of the previous cycle (1-cycle latency).
REQ-032 rd_sel >= NUM_CH SHALL return 0 on all rd_* outputs.

Reset
REQ-033 reset=1 SHALL immediately force all FSMs to IDLE, lat=0, ch_busy=0 and frozen=0.
REQ-034 reset=1 SHALL immediately force all counters and rd_* outputs to 0, except min_lat and rd_min_lat, which go to all-ones.
REQ-035 Reset asserted mid-transaction SHALL discard the in-flight transaction with no count.

Verification
REQ-036 Bench SHALL cover: ch0 start at cycle 10, done at cycle 19, continue=1 -> rd_txn_cnt=1, rd_last_lat=10, rd_min_lat=10, rd_max_lat=10.
REQ-037 Bench SHALL cover: ch1 done at latency 5 with continue=0 for 3 cycles, then continue=1 -> rd_stall_cyc=3, rd_txn_cnt=1, rd_last_lat=5.
REQ-038 Bench SHALL cover: ch2 back-to-back (start with done+continue), latencies 4 then 6 -> rd_txn_cnt=2, min=4, max=6, last=6; ch_busy[2] stays 1 between them.
REQ-039 Bench SHALL cover: CNT_W=8, one transaction of latency 300 -> rd_last_lat=255 (saturated).
REQ-040 Bench SHALL cover: finish pulse, then a further ch0 transaction -> frozen=1 and ch0 statistics unchanged; clear during BUSY followed by completion -> rd_txn_cnt=1 and lat includes the pre-clear cycles.
REQ-041 Bench SHALL cover: reset asserted while ch3 is in BUSY -> ch_busy=0 in the same cycle; rd_txn_cnt=0 and rd_min_lat=all-ones after release.
